irq_pending_latch: RTL

Upstream request-capture stage for the 8-input priority encoder path. Detects rising edges on eight request lines and holds them as sticky pending bits, gated by a writable enable mask. Selects the highest-numbered pending, enabled line (bit 7 highest) and presents its 3-bit index with a valid/ack handshake. An acknowledge clears only the presented bit; an unacknowledged grant is withdrawn after a timeout and re-arbitrated.

---
 rtl/irq_pending_latch.sv | 111 +++++++++++
 1 files changed

// File: rtl/irq_pending_latch.sv
// Request capture with sticky pending bits, enable mask and a single-grant
// valid/ack handshake that is withdrawn after TIMEOUT unacknowledged cycles.
module irq_pending_latch #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic [7:0] i_req,
    input  logic       i_mask_wr,
    input  logic [7:0] i_mask_in,
    input  logic       i_ack,
    output logic       o_irq_valid,
    output logic [2:0] o_irq_id,
    output logic [7:0] o_pending,
    output logic [7:0] o_mask
);

    typedef enum logic {
        StIdle,
        StIssue
    } state_t;

    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic [2:0] r_irq_id;
    logic [7:0] r_pending;
    logic [7:0] r_mask;
    logic [7:0] r_req_d;

    state_t     w_state_next;
    logic [7:0] w_cnt_next;
    logic [2:0] w_id_next;
    logic [7:0] w_clr;
    logic [7:0] w_rise;
    logic [7:0] w_elig;
    logic [2:0] w_hi_idx;

    assign w_rise = i_req & ~r_req_d;
    assign w_elig = r_pending & r_mask;

    // Ascending scan: the last set bit seen is the highest-numbered one.
    always_comb begin
        w_hi_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_elig[i]) begin
                w_hi_idx = 3'(i);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_id_next    = r_irq_id;
        w_clr        = 8'h00;
        unique case (r_state)
            StIdle: begin
                if (i_en && (w_elig != 8'h00)) begin
                    w_id_next    = w_hi_idx;
                    w_cnt_next   = 8'h00;
                    w_state_next = StIssue;
                end
            end
            StIssue: begin
                if (i_ack) begin
                    w_clr        = 8'h01 << r_irq_id;
                    w_state_next = StIdle;
                end else if (!i_en) begin
                    w_state_next = StIdle;
                end else if (r_cnt == CntLast) begin
                    w_state_next = StIdle;
                end else begin
                    w_cnt_next = r_cnt + 8'h01;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_cnt     <= 8'h00;
            r_irq_id  <= 3'd0;
            r_pending <= 8'h00;
            r_mask    <= 8'hFF;
            r_req_d   <= 8'h00;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_irq_id  <= w_id_next;
            // A fresh rising edge wins over an ack clear of the same bit.
            r_pending <= (r_pending & ~w_clr) | w_rise;
            r_req_d   <= i_req;
            if (i_mask_wr) begin
                r_mask <= i_mask_in;
            end
        end
    end

    assign o_irq_valid = (r_state == StIssue);
    assign o_irq_id    = r_irq_id;
    assign o_pending   = r_pending;
    assign o_mask      = r_mask;

endmodule
